// File: rtl/alu_pkg.sv
// Shared opcodes, sign-class encodings and FSM states for the EX-stage ALU/MDU.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_MULTU = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    localparam logic [1:0] N_ZERO = 2'b01;
    localparam logic [1:0] N_NEG  = 2'b10;
    localparam logic [1:0] N_POS  = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StExec   = 2'b01,
        StFinish = 2'b10
    } state_e;

    function automatic logic [1:0] n_class(input logic is_zero, input logic msb);
        if (is_zero) begin
            return N_ZERO;
        end else if (msb) begin
            return N_NEG;
        end else begin
            return N_POS;
        end
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per step.
// hi/lo present the {acc, q} value that the current step will produce.
module mdu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;

    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_y;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_prod;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // One shared adder: acc + m for multiply, {acc,q_msb} - m for divide.
    assign w_x   = r_is_div ? {r_acc, r_q[WIDTH-1]} : {1'b0, r_acc};
    assign w_y   = r_is_div ? ~{1'b0, r_m} : {1'b0, r_m};
    assign w_sum = w_x + w_y + {{WIDTH{1'b0}}, r_is_div};

    always_comb begin
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        w_prod    = {1'b0, r_acc};
        if (r_is_div) begin
            if (!w_sum[WIDTH]) begin
                w_acc_nxt = w_sum[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_q[0]) begin
                w_prod = w_sum;
            end
            w_acc_nxt = w_prod[WIDTH:1];
            w_q_nxt   = {w_prod[0], r_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
        end else if (load) begin
            r_acc    <= '0;
            r_q      <= a;
            r_m      <= b;
            r_is_div <= is_div;
            r_cnt    <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign hi   = w_acc_nxt;
    assign lo   = w_q_nxt;
    assign last = (r_cnt == '0);

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with multi-cycle MULTU/DIVU and a start/busy/done handshake.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       n,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_b_zero;
    logic             w_multi;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic             w_last;

    assign w_accept = start && (r_state != StExec);
    assign w_b_zero = (b == '0);
    assign w_multi  = (alu_op == OP_MULTU) || ((alu_op == OP_DIVU) && !w_b_zero);

    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_XOR:  w_alu = a ^ b;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_DIVU: w_alu = '1;  // only reached with b == 0
            default: w_alu = '0;
        endcase
    end

    mdu_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mdu_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_accept && w_multi),
        .step   (r_state == StExec),
        .is_div (alu_op == OP_DIVU),
        .a      (a),
        .b      (b),
        .hi     (w_core_hi),
        .lo     (w_core_lo),
        .last   (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_result   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                StExec: begin
                    if (w_last) begin
                        r_state  <= StFinish;
                        r_hi     <= w_core_hi;
                        r_lo     <= w_core_lo;
                        r_result <= w_core_lo;
                    end
                end
                default: begin
                    if (start) begin
                        r_div_zero <= (alu_op == OP_DIVU) && w_b_zero;
                        if (w_multi) begin
                            r_state <= StExec;
                        end else begin
                            r_state  <= StFinish;
                            r_result <= w_alu;
                            if (alu_op == OP_DIVU) begin
                                r_hi <= a;
                                r_lo <= '1;
                            end
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

    assign result   = r_result;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;
    assign busy     = (r_state == StExec);
    assign done     = (r_state == StFinish);
    assign zero     = (r_result == '0);
    assign n        = n_class(zero, r_result[WIDTH-1]);

endmodule
